arbitro_mem_externa: RTL and testbench
======================================

// Module: arbitro_mem_externa
// PURPOSE
//  Shares the single-port external image memory between two requesters: the read path
//  (the external-memory read controller feeding the line buffers) and the write-back path
//  (filtered pixels). One transaction in flight at a time; round-robin or fixed priority.
//  Sits between both controllers and the memory interface; forwards memory completion
//  back to the granted requester only.
// PARAMETERS
//  ADDR_W  21  memory word address width
//  DATA_W  16  memory word width
// PORTS
//  clk          in   1       single clock, rising edge
//  reset        in   1       synchronous, active-high
//  rd_req       in   1       read request; level, held until rd_done
//  rd_addr      in   ADDR_W  read address; stable while rd_req=1
//  rd_done      out  1       1-cycle pulse, rd_data valid
//  rd_data      out  DATA_W  captured mem_rdata; held until next read completes
//  wr_req       in   1       write request; level, held until wr_done
//  wr_addr      in   ADDR_W  write address; stable while wr_req=1
//  wr_data      in   DATA_W  write data; stable while wr_req=1
//  wr_done      out  1       1-cycle pulse, write accepted by memory
//  mem_read     out  1       read strobe to memory, held until mem_done
//  mem_write    out  1       write strobe to memory, held until mem_done
//  mem_address  out  ADDR_W  latched address of granted transaction
//  mem_wdata    out  DATA_W  latched write data
//  mem_rdata    in   DATA_W  read data, valid when mem_done=1 in READ
//  mem_done     in   1       memory completion pulse (read or write)
//  busy         out  1       1 whenever state != IDLE
// BEHAVIOUR
//  - Reset: all outputs 0 (rd_data, mem_address, mem_wdata included); state IDLE;
//    last_grant=WRITE so the first contended grant goes to read. Reset mid-transaction
//    abandons it: strobes drop next edge, no done pulse issued.
//  - FSM: IDLE -> READ | WRITE -> RELEASE -> IDLE. All outputs registered.
//  - IDLE: at edge with rd_req|wr_req, pick winner, latch address (and wr_data), enter
//    READ/WRITE; strobe high in the first cycle after that edge (latency 1).
//  - READ/WRITE: strobe and mem_address held constant until mem_done sampled high;
//    at that edge: strobe->0, rd_data<=mem_rdata (READ only), done pulse for exactly the
//    cycle spent in RELEASE, state->RELEASE.
//  - RELEASE: 1 dead cycle; requester must drop req at edge where it samples done, so
//    IDLE never re-grants a completed request. Min spacing strobe-to-strobe = 3 cycles.
//  - mem_done ignored in IDLE and RELEASE. Req changes while not IDLE are ignored.
//  - mem_read and mem_write never high together; rd_done/wr_done never high together.
//  - Requests deasserted before grant are simply dropped (no latching of req pulses).
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: on simultaneous rd_req & wr_req, grant the side opposite
//    last_grant; last_grant updated on every grant.
//  Not defined: fixed priority, read always wins over write; last_grant register absent.
//  Single requester active: granted immediately in both modes.
// STRUCTURE
//  Shared include arbitro_defs.vh: FSM state localparams (IDLE, READ, WRITE, RELEASE),
//    GRANT_RD/GRANT_WR encodings, ADDR_W/DATA_W defaults.
//  Sub-module arbitro_rr_sel: 2-input selector (req_a, req_b, last -> grant), houses
//    the ARB_ROUND_ROBIN_EN conditional; FSM, latches and strobes stay in the top.
// TESTING
//  1. reset 1 cycle, then idle 5 cycles -> all outputs 0, busy=0, no strobes.
//  2. rd_req=1, rd_addr=1; mem_done 4 cycles after mem_read, mem_rdata=16'hA5A5 ->
//     mem_read high 1 cycle after req edge, mem_address=1, rd_done 1 cycle, rd_data=A5A5.
//  3. wr_req=1, wr_addr=7, wr_data=16'h0033 -> mem_write held until mem_done,
//     mem_wdata=0033, wr_done 1 cycle, mem_read stays 0.
//  4. rd_req & wr_req same edge, held for 3 transactions: with ARB_ROUND_ROBIN_EN grant
//     order R,W,R; without: R,R,R (write starved while rd_req held).
//  5. mem_done pulsed while IDLE, and during RELEASE -> ignored, no done pulse, state kept.
//  6. reset asserted 2 cycles into READ -> mem_read 0 next cycle, rd_done never pulses,
//     busy=0; fresh rd_req afterwards completes normally.

Source files
------------

// File: rtl/arbitro_mem_externa_pkg.sv
// Shared types and default widths for the external-memory arbiter (read path vs write-back path).
// The round-robin option is selected by ARB_ROUND_ROBIN_EN in arbitro_rr_sel.
package arbitro_mem_externa_pkg;

  localparam int ADDR_W_DEF = 21;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_WRITE   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_t;

endpackage

// File: rtl/arbitro_mem_externa_rr_sel.sv
// Combinational 2-way grant selector (a = read, b = write); zero latency, no state.
// ARB_ROUND_ROBIN_EN defined: contention alternates against last_i; otherwise read always wins.
module arbitro_rr_sel
  import arbitro_mem_externa_pkg::*;
(
  input  logic   req_a_i,
  input  logic   req_b_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  grant_t last_i,
`endif
  output grant_t grant_o
);

  always_comb begin
    grant_o = GRANT_RD;
    if (!req_a_i) begin
      grant_o = GRANT_WR;
    end
`ifdef ARB_ROUND_ROBIN_EN
    else if (req_b_i) begin
      grant_o = (last_i == GRANT_RD) ? GRANT_WR : GRANT_RD;
    end
`else
    else if (req_b_i) begin
      grant_o = GRANT_RD;
    end
`endif
  end

endmodule

// File: rtl/arbitro_mem_externa.sv
// Single-port external memory arbiter: one transaction in flight, strobe 1 cycle after the grant edge,
// done pulse during a 1-cycle RELEASE; requesters wait on level req. Option macro: ARB_ROUND_ROBIN_EN.
module arbitro_mem_externa
  import arbitro_mem_externa_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_done_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_done_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_done_i,
  output logic              busy_o
);

  state_t              state_q, state_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_done_q, rd_done_d;
  logic                wr_done_q, wr_done_d;
  grant_t              grant;

`ifdef ARB_ROUND_ROBIN_EN
  grant_t              last_q, last_d;

  arbitro_rr_sel u_sel (
    .req_a_i (rd_req_i),
    .req_b_i (wr_req_i),
    .last_i  (last_q),
    .grant_o (grant)
  );
`else
  arbitro_rr_sel u_sel (
    .req_a_i (rd_req_i),
    .req_b_i (wr_req_i),
    .grant_o (grant)
  );
`endif

  always_comb begin
    state_d       = state_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    rd_data_d     = rd_data_q;
    rd_done_d     = 1'b0;
    wr_done_d     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d        = last_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (rd_req_i || wr_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
          last_d = grant;
`endif
          if (grant == GRANT_RD) begin
            state_d       = ST_READ;
            mem_read_d    = 1'b1;
            mem_address_d = rd_addr_i;
          end else begin
            state_d       = ST_WRITE;
            mem_write_d   = 1'b1;
            mem_address_d = wr_addr_i;
            mem_wdata_d   = wr_data_i;
          end
        end
      end
      ST_READ: begin
        if (mem_done_i) begin
          state_d    = ST_RELEASE;
          mem_read_d = 1'b0;
          rd_data_d  = mem_rdata_i;
          rd_done_d  = 1'b1;
        end
      end
      ST_WRITE: begin
        if (mem_done_i) begin
          state_d     = ST_RELEASE;
          mem_write_d = 1'b0;
          wr_done_d   = 1'b1;
        end
      end
      // The dead cycle lets the requester drop req before IDLE samples it again.
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      rd_data_q     <= '0;
      rd_done_q     <= 1'b0;
      wr_done_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q        <= GRANT_WR;
`endif
    end else begin
      state_q       <= state_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      rd_data_q     <= rd_data_d;
      rd_done_q     <= rd_done_d;
      wr_done_q     <= wr_done_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q        <= last_d;
`endif
    end
  end

  assign mem_read_o    = mem_read_q;
  assign mem_write_o   = mem_write_q;
  assign mem_address_o = mem_address_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign rd_data_o     = rd_data_q;
  assign rd_done_o     = rd_done_q;
  assign wr_done_o     = wr_done_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_arbitro_mem_externa.sv
// Bench for arbitro_mem_externa: vector table, reset/contention sequences, randomized run vs a transaction model.
module tb_arbitro_mem_externa;
  import arbitro_mem_externa_pkg::*;

  localparam int AW = ADDR_W_DEF;
  localparam int DW = DATA_W_DEF;
  localparam int OW = 2 + AW + DW + 3 + DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i, rd_req_i, wr_req_i, mem_done_i;
  logic [AW-1:0] rd_addr_i, wr_addr_i;
  logic [DW-1:0] wr_data_i, mem_rdata_i;
  logic          rd_done_o, wr_done_o, mem_read_o, mem_write_o, busy_o;
  logic [DW-1:0] rd_data_o, mem_wdata_o;
  logic [AW-1:0] mem_address_o;

  arbitro_mem_externa #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_done_o(rd_done_o), .rd_data_o(rd_data_o),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_done_o(wr_done_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_address_o(mem_address_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_done_i(mem_done_i),
    .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic rst, rq, wq, md;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd, mrd;
    logic er, ew, erdn, ewdn, eb;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewdat, erdat;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [OW-1:0] pk(input logic r, input logic w, input logic [AW-1:0] a,
                                       input logic [DW-1:0] wd, input logic rdn, input logic wdn,
                                       input logic b, input logic [DW-1:0] rdat);
    return {r, w, a, wd, rdn, wdn, b, rdat};
  endfunction

  function automatic logic [OW-1:0] outs();
    return pk(mem_read_o, mem_write_o, mem_address_o, mem_wdata_o, rd_done_o, wr_done_o, busy_o, rd_data_o);
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (rd,wr,addr,wdata,rdone,wdone,busy,rdata)", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset_i = 1'b1; rd_req_i = 1'b0; wr_req_i = 1'b0; mem_done_i = 1'b0;
    tick();
    reset_i = 1'b0;
  endtask

  function automatic vec_t mk(input logic rst, input logic rq, input int ra, input logic wq, input int wa,
                              input int wd, input logic md, input int mrd,
                              input logic er, input logic ew, input int ea, input int ewdat,
                              input logic erdn, input logic ewdn, input logic eb, input int erdat);
    vec_t v;
    v.rst = rst; v.rq = rq; v.ra = AW'(ra); v.wq = wq; v.wa = AW'(wa); v.wd = DW'(wd);
    v.md = md; v.mrd = DW'(mrd);
    v.er = er; v.ew = ew; v.ea = AW'(ea); v.ewdat = DW'(ewdat);
    v.erdn = erdn; v.ewdn = ewdn; v.eb = eb; v.erdat = DW'(erdat);
    return v;
  endfunction

  function automatic int pick(input bit rq, input bit wq, input int last);
    if (rq && wq) begin
`ifdef ARB_ROUND_ROBIN_EN
      return (last == 2) ? 1 : 2;
`else
      return 1;
`endif
    end
    return rq ? 1 : 2;
  endfunction

  initial begin
    int n;
    int order[3];
    bit both, seen_done, rd_pend, wr_pend, rq, wq, md, cool, erdn, ewdn;
    int cur, last;
    logic [AW-1:0] ra, wa, ea;
    logic [DW-1:0] wd, mrd, ewdat, erdat;
    logic pr, pw;

    reset_i = 1'b1; rd_req_i = 1'b0; wr_req_i = 1'b0; mem_done_i = 1'b0;
    rd_addr_i = '0; wr_addr_i = '0; wr_data_i = '0; mem_rdata_i = '0;

    // rst rq ra wq wa wd md mrd | er ew ea ewdat erdn ewdn eb erdat
    tbl.push_back(mk(1,0,0, 0,0,0, 0,0,       0,0,0,0,      0,0,0,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,0,0, 0,0,0, 0,0,     0,0,0,0,      0,0,0,0));
    tbl.push_back(mk(0,1,1, 0,0,0, 0,0,       1,0,1,0,      0,0,1,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,1, 0,0,0, 0,0,     1,0,1,0,      0,0,1,0));
    tbl.push_back(mk(0,1,1, 0,0,0, 1,'hA5A5,  0,0,1,0,      1,0,1,'hA5A5));
    tbl.push_back(mk(0,1,1, 0,0,0, 0,0,       0,0,1,0,      0,0,0,'hA5A5));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,       0,0,1,0,      0,0,0,'hA5A5));
    tbl.push_back(mk(0,0,0, 1,7,'h33, 0,0,    0,1,7,'h33,   0,0,1,'hA5A5));
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(0,0,0, 1,7,'h33, 0,0,  0,1,7,'h33,   0,0,1,'hA5A5));
    tbl.push_back(mk(0,0,0, 1,7,'h33, 1,'h9999, 0,0,7,'h33, 0,1,1,'hA5A5));
    tbl.push_back(mk(0,0,0, 1,7,'h33, 0,0,    0,0,7,'h33,   0,0,0,'hA5A5));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,       0,0,7,'h33,   0,0,0,'hA5A5));
    tbl.push_back(mk(0,0,0, 0,0,0, 1,'hFFFF,  0,0,7,'h33,   0,0,0,'hA5A5));
    tbl.push_back(mk(0,1,3, 0,0,0, 1,'hEEEE,  1,0,3,'h33,   0,0,1,'hA5A5));
    tbl.push_back(mk(0,1,3, 0,0,0, 1,'h1111,  0,0,3,'h33,   1,0,1,'h1111));
    tbl.push_back(mk(0,1,3, 0,0,0, 1,'h2222,  0,0,3,'h33,   0,0,0,'h1111));
    tbl.push_back(mk(0,0,0, 0,0,0, 1,'h3333,  0,0,3,'h33,   0,0,0,'h1111));

    foreach (tbl[i]) begin
      reset_i = tbl[i].rst; rd_req_i = tbl[i].rq; rd_addr_i = tbl[i].ra;
      wr_req_i = tbl[i].wq; wr_addr_i = tbl[i].wa; wr_data_i = tbl[i].wd;
      mem_done_i = tbl[i].md; mem_rdata_i = tbl[i].mrd;
      tick();
      check($sformatf("vec%0d", i), outs(),
            pk(tbl[i].er, tbl[i].ew, tbl[i].ea, tbl[i].ewdat, tbl[i].erdn, tbl[i].ewdn, tbl[i].eb, tbl[i].erdat));
    end

    // Reset two cycles into a read abandons it silently.
    reset_dut();
    rd_req_i = 1'b1; rd_addr_i = AW'(5);
    tick();
    check("rst_mid_grant", outs(), pk(1,0,AW'(5),'0,0,0,1,'0));
    tick(); tick();
    reset_i = 1'b1;
    tick();
    check("rst_mid_abort", outs(), pk(0,0,'0,'0,0,0,0,'0));
    reset_i = 1'b0; rd_req_i = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rd_done_o || wr_done_o || busy_o) seen_done = 1'b1;
    end
    check_bit("rst_mid_quiet", seen_done, 1'b0);
    rd_req_i = 1'b1; rd_addr_i = AW'(9);
    tick();
    mem_done_i = 1'b1; mem_rdata_i = DW'('h5A5A);
    tick();
    check("rst_mid_fresh_done", outs(), pk(0,0,AW'(9),'0,1,0,1,DW'('h5A5A)));
    mem_done_i = 1'b0;
    tick();
    rd_req_i = 1'b0;
    check("rst_mid_fresh_idle", outs(), pk(0,0,AW'(9),'0,0,0,0,DW'('h5A5A)));

    // Both requesters held through three grants.
    reset_dut();
    rd_req_i = 1'b1; wr_req_i = 1'b1; rd_addr_i = AW'(10); wr_addr_i = AW'(20); wr_data_i = DW'('hBEEF);
    n = 0; both = 1'b0; pr = 1'b0; pw = 1'b0;
    order[0] = 0; order[1] = 0; order[2] = 0;
    for (int c = 0; c < 60 && n < 3; c++) begin
      tick();
      if (mem_read_o && mem_write_o) both = 1'b1;
      if (mem_read_o && !pr) begin order[n] = 1; n++; end
      else if (mem_write_o && !pw) begin order[n] = 2; n++; end
      pr = mem_read_o; pw = mem_write_o;
      mem_done_i = (mem_read_o || mem_write_o) && !mem_done_i;
    end
    seen_done = 1'b0;
    for (int c = 0; c < 10 && !seen_done; c++) begin
      tick();
      if (mem_read_o && mem_write_o) both = 1'b1;
      if (rd_done_o || wr_done_o) seen_done = 1'b1;
      mem_done_i = (mem_read_o || mem_write_o) && !mem_done_i;
    end
    rd_req_i = 1'b0; wr_req_i = 1'b0; mem_done_i = 1'b0;
    checks++;
`ifdef ARB_ROUND_ROBIN_EN
    if (n != 3 || order[0] != 1 || order[1] != 2 || order[2] != 1) begin
      errors++;
      $display("FAIL contend_order: got n=%0d %0d,%0d,%0d expected 1,2,1", n, order[0], order[1], order[2]);
    end
`else
    if (n != 3 || order[0] != 1 || order[1] != 1 || order[2] != 1) begin
      errors++;
      $display("FAIL contend_order: got n=%0d %0d,%0d,%0d expected 1,1,1", n, order[0], order[1], order[2]);
    end
`endif
    check_bit("contend_excl", both, 1'b0);
    check_bit("contend_last_done", seen_done, 1'b1);
    tick(); tick();
    check_bit("contend_idle_busy", busy_o, 1'b0);

    // Randomized run against a transaction-level model.
    reset_dut();
    cur = 0; cool = 1'b0; last = 2; ea = '0; ewdat = '0; erdat = '0;
    rd_pend = 1'b0; wr_pend = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!rd_pend && $urandom_range(0, 3) == 0) begin
        rd_pend = 1'b1; rd_addr_i = AW'($urandom);
      end else if (rd_pend && cur != 1 && $urandom_range(0, 15) == 0) begin
        rd_pend = 1'b0;
      end
      if (!wr_pend && $urandom_range(0, 3) == 0) begin
        wr_pend = 1'b1; wr_addr_i = AW'($urandom); wr_data_i = DW'($urandom);
      end else if (wr_pend && cur != 2 && $urandom_range(0, 15) == 0) begin
        wr_pend = 1'b0;
      end
      rd_req_i = rd_pend; wr_req_i = wr_pend;
      mem_done_i = ($urandom_range(0, 2) == 0);
      mem_rdata_i = DW'($urandom);
      rq = rd_req_i; wq = wr_req_i; md = mem_done_i;
      ra = rd_addr_i; wa = wr_addr_i; wd = wr_data_i; mrd = mem_rdata_i;
      tick();
      erdn = 1'b0; ewdn = 1'b0;
      if (cur != 0) begin
        if (md) begin
          if (cur == 1) begin erdn = 1'b1; erdat = mrd; end
          else ewdn = 1'b1;
          cur = 0; cool = 1'b1;
        end
      end else if (cool) begin
        cool = 1'b0;
      end else if (rq || wq) begin
        cur = pick(rq, wq, last);
        last = cur;
        if (cur == 1) ea = ra;
        else begin ea = wa; ewdat = wd; end
      end
      check($sformatf("rand%0d", c), outs(),
            pk(cur == 1, cur == 2, ea, ewdat, erdn, ewdn, (cur != 0) || cool, erdat));
      if (erdn) rd_pend = 1'b0;
      if (ewdn) wr_pend = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
